// File: rtl/mdc_pkg.sv
// Shared definitions for the coffee-machine plant model.
//   - Actuator bit positions inside the controller's salida[7:0] command word.
//   - Sensor condition numbering (hm..tm = 1..6) as seen by the controller.
package mdc_pkg;

  localparam int ACT_ACCEPT  = 0;  // accept coin: clear coin latch
  localparam int ACT_VALVE   = 1;  // water valve open
  localparam int ACT_HEAT    = 2;  // heater on
  localparam int ACT_DISP    = 3;  // dispense one coffee dose (rising edge)
  localparam int ACT_CLR_BTN = 4;  // clear button latches
  localparam int ACT_SERVE   = 5;  // serve done (rising edge)
  localparam int ACT_RETURN  = 6;  // return coin: clear coin latch
  localparam int ACT_FAULT   = 7;  // fault lamp

  typedef enum logic [2:0] {
    COND_HM = 3'd1,
    COND_HA = 3'd2,
    COND_BP = 3'd3,
    COND_BB = 3'd4,
    COND_HC = 3'd5,
    COND_TM = 3'd6
  } cond_e;

endpackage

// File: rtl/mdc_sat_counter.sv
// Saturating up/down level counter with synchronous load.
// Ports:
//   clk, rst     clock, synchronous active-high reset (loads RST_VAL)
//   i_load       load i_load_val this cycle (beats inc/dec)
//   i_load_val   value to load
//   i_inc/i_dec  step up (stops at MAX) / step down (stops at 0)
//   o_q          registered level
//   o_q_nxt      level after the coming edge, for flags that must
//                change together with the level
module mdc_sat_counter #(
  parameter int LVL_W   = 4,
  parameter int MAX     = 15,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [LVL_W-1:0] i_load_val,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [LVL_W-1:0] o_q,
  output logic [LVL_W-1:0] o_q_nxt
);

  localparam logic [LVL_W-1:0] MAX_V = LVL_W'(MAX);
  localparam logic [LVL_W-1:0] RST_V = LVL_W'(RST_VAL);

  logic [LVL_W-1:0] r_q;
  logic [LVL_W-1:0] w_nxt;

  always_comb begin
    w_nxt = r_q;
    if (i_load) begin
      w_nxt = i_load_val;
    end else if (i_inc && !i_dec) begin
      if (r_q < MAX_V) w_nxt = r_q + 1'b1;
    end else if (i_dec && !i_inc) begin
      if (r_q != '0) w_nxt = r_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_q <= RST_V;
    else     r_q <= w_nxt;
  end

  assign o_q     = r_q;
  assign o_q_nxt = w_nxt;

endmodule

// File: rtl/mdc_plant_model.sv
// Coffee-machine plant emulator: takes the controller's 8 actuator commands
// and returns the 6 sensor conditions it samples. Models the coin latch,
// cup-size button latches, water tank, coffee stock and heater temperature.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   coin_ev, btn_s_ev,
//   btn_b_ev, refill_ev      single-cycle environment events
//   salida[7:0]              actuator commands (bit map in mdc_pkg)
//   hm ha bp bb hc tm        registered sensor conditions
//   water_lvl, coffee_lvl    current levels
//   cups                     served-cup count, wraps 255->0
//   fault_seen               sticky: fault lamp seen since reset
module mdc_plant_model
  import mdc_pkg::*;
#(
  parameter int LVL_W      = 4,
  parameter int TANK_MAX   = 15,
  parameter int WATER_MIN  = 6,
  parameter int COFFEE_MAX = 10,
  parameter int HEAT_CYC   = 8,
  parameter int COOL_DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_ev,
  input  logic             btn_s_ev,
  input  logic             btn_b_ev,
  input  logic             refill_ev,
  input  logic [7:0]       salida,
  output logic             hm,
  output logic             ha,
  output logic             bp,
  output logic             bb,
  output logic             hc,
  output logic             tm,
  output logic [LVL_W-1:0] water_lvl,
  output logic [LVL_W-1:0] coffee_lvl,
  output logic [7:0]       cups,
  output logic             fault_seen
);

  localparam logic [LVL_W-1:0] TANK_V   = LVL_W'(TANK_MAX);
  localparam logic [LVL_W-1:0] COFFEE_V = LVL_W'(COFFEE_MAX);
  localparam logic [LVL_W-1:0] WMIN_V   = LVL_W'(WATER_MIN);
  localparam logic [LVL_W-1:0] HEAT_V   = LVL_W'(HEAT_CYC);
  localparam logic [LVL_W-1:0] COOL_TOP = LVL_W'(COOL_DIV - 1);

  logic             r_hm, r_ha, r_bp, r_bb, r_hc, r_tm;
  logic             r_disp_d, r_serve_d;
  logic [LVL_W-1:0] r_cool;
  logic [7:0]       r_cups;
  logic             r_fault;

  logic             w_disp_rise, w_serve_rise, w_heat, w_cool_tick;
  logic [LVL_W-1:0] w_water, w_water_nxt;
  logic [LVL_W-1:0] w_coffee, w_coffee_nxt;
  logic [LVL_W-1:0] w_temp, w_temp_nxt;
  logic             w_bp_nxt, w_bb_nxt;

  assign w_heat       = salida[ACT_HEAT];
  assign w_disp_rise  = salida[ACT_DISP]  & ~r_disp_d;
  assign w_serve_rise = salida[ACT_SERVE] & ~r_serve_d;
  // Cooling step fires on the last prescaler count; at temp 0 there is
  // nothing left to cool, so the prescaler parks (unobservable either way).
  assign w_cool_tick  = !w_heat && (w_temp != '0) && (r_cool == COOL_TOP);

  mdc_sat_counter #(.LVL_W(LVL_W), .MAX(TANK_MAX), .RST_VAL(TANK_MAX)) u_water (
    .clk        (clk),
    .rst        (rst),
    .i_load     (refill_ev),
    .i_load_val (TANK_V),
    .i_inc      (1'b0),
    .i_dec      (salida[ACT_VALVE]),
    .o_q        (w_water),
    .o_q_nxt    (w_water_nxt)
  );

  mdc_sat_counter #(.LVL_W(LVL_W), .MAX(COFFEE_MAX), .RST_VAL(COFFEE_MAX)) u_coffee (
    .clk        (clk),
    .rst        (rst),
    .i_load     (refill_ev),
    .i_load_val (COFFEE_V),
    .i_inc      (1'b0),
    .i_dec      (w_disp_rise),
    .o_q        (w_coffee),
    .o_q_nxt    (w_coffee_nxt)
  );

  mdc_sat_counter #(.LVL_W(LVL_W), .MAX(HEAT_CYC), .RST_VAL(0)) u_temp (
    .clk        (clk),
    .rst        (rst),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_heat),
    .i_dec      (w_cool_tick),
    .o_q        (w_temp),
    .o_q_nxt    (w_temp_nxt)
  );

  // Button latches: big cup overrides small, a set beats the clear command,
  // and a small press while big is latched is dropped.
  always_comb begin
    w_bp_nxt = r_bp;
    w_bb_nxt = r_bb;
    if (btn_b_ev) begin
      w_bb_nxt = 1'b1;
      w_bp_nxt = 1'b0;
    end else if (btn_s_ev && !r_bb) begin
      w_bp_nxt = 1'b1;
    end else if (salida[ACT_CLR_BTN]) begin
      w_bp_nxt = 1'b0;
      w_bb_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hm      <= 1'b0;
      r_ha      <= 1'b1;
      r_bp      <= 1'b0;
      r_bb      <= 1'b0;
      r_hc      <= 1'b1;
      r_tm      <= 1'b0;
      r_disp_d  <= 1'b0;
      r_serve_d <= 1'b0;
      r_cool    <= '0;
      r_cups    <= 8'd0;
      r_fault   <= 1'b0;
    end else begin
      // Coin set wins over accept/return in the same cycle.
      if (coin_ev)                                      r_hm <= 1'b1;
      else if (salida[ACT_ACCEPT] | salida[ACT_RETURN]) r_hm <= 1'b0;

      r_bp <= w_bp_nxt;
      r_bb <= w_bb_nxt;

      // Flags follow the next-state levels so they move with the level outputs.
      r_ha <= (w_water_nxt >= WMIN_V);
      r_hc <= (w_coffee_nxt != '0);
      r_tm <= (w_temp_nxt == HEAT_V);

      r_disp_d  <= salida[ACT_DISP];
      r_serve_d <= salida[ACT_SERVE];

      if (w_heat || w_cool_tick || (w_temp == '0)) r_cool <= '0;
      else                                         r_cool <= r_cool + 1'b1;

      if (w_serve_rise) r_cups <= r_cups + 8'd1;

      if (salida[ACT_FAULT]) r_fault <= 1'b1;
    end
  end

  assign hm         = r_hm;
  assign ha         = r_ha;
  assign bp         = r_bp;
  assign bb         = r_bb;
  assign hc         = r_hc;
  assign tm         = r_tm;
  assign water_lvl  = w_water;
  assign coffee_lvl = w_coffee;
  assign cups       = r_cups;
  assign fault_seen = r_fault;

endmodule
